// File: rtl/metaball_motion_sched.sv
// rtl/metaball_motion_sched.sv - per-frame metaball motion scheduler with edge bounce and atomic commit
// Optional build macro METABALL_PAUSE_EN adds a pause input that gates starting an update.
module metaball_motion_sched #(
   parameter int NUM_BALLS = 3,
   parameter int COORD_W   = 10,
   parameter int VEL_W     = 4,
   parameter int X_MAX     = 639,
   parameter int Y_MAX     = 479
) (
   input  logic                           clk,
   input  logic                           reset,
   input  logic                           frame_tick,
   input  logic                           display,
`ifdef METABALL_PAUSE_EN
   input  logic                           pause,
`endif
   output logic [NUM_BALLS*COORD_W-1:0]   ball_x,
   output logic [NUM_BALLS*COORD_W-1:0]   ball_y,
   output logic                           busy,
   output logic                           overrun,
   output logic [7:0]                     frame_count
);

   localparam int SW    = COORD_W + 2;
   localparam int IDX_W = (NUM_BALLS > 1) ? $clog2(NUM_BALLS) : 1;
   localparam logic signed [SW-1:0] X_LIM = SW'(X_MAX);
   localparam logic signed [SW-1:0] Y_LIM = SW'(Y_MAX);
   localparam logic [COORD_W-1:0]   RST_Y = COORD_W'(Y_MAX / 2);
   localparam logic [IDX_W-1:0]     LAST  = IDX_W'(NUM_BALLS - 1);

   typedef enum logic [1:0] {IDLE, UPDATE, COMMIT} state_t;

   state_t                     state;
   logic [IDX_W-1:0]           idx;
   logic [COORD_W-1:0]         x_sh [NUM_BALLS];
   logic [COORD_W-1:0]         y_sh [NUM_BALLS];
   logic signed [VEL_W-1:0]    vx   [NUM_BALLS];
   logic signed [VEL_W-1:0]    vy   [NUM_BALLS];

   logic signed [SW-1:0]       nx, ny;
   logic [COORD_W-1:0]         x_new, y_new;
   logic signed [VEL_W-1:0]    vx_new, vy_new;
   logic                       paused;

`ifdef METABALL_PAUSE_EN
   assign paused = pause;
`else
   assign paused = 1'b0;
`endif

   function automatic logic [COORD_W-1:0] rst_x(input int i);
      return COORD_W'((i + 1) * X_MAX / (NUM_BALLS + 1));
   endfunction

   function automatic logic signed [VEL_W-1:0] rst_vx(input int i);
      return VEL_W'(i + 1);
   endfunction

   function automatic logic signed [VEL_W-1:0] rst_vy(input int i);
      return (i % 2 == 0) ? VEL_W'(2) : VEL_W'(-2);
   endfunction

   // Step the ball selected by idx; a bounce clamps to the edge and reverses that axis.
   always_comb begin
      nx     = $signed({2'b00, x_sh[idx]}) + $signed({{(SW-VEL_W){vx[idx][VEL_W-1]}}, vx[idx]});
      ny     = $signed({2'b00, y_sh[idx]}) + $signed({{(SW-VEL_W){vy[idx][VEL_W-1]}}, vy[idx]});
      x_new  = nx[COORD_W-1:0];
      y_new  = ny[COORD_W-1:0];
      vx_new = vx[idx];
      vy_new = vy[idx];
      if (nx < 0) begin
         x_new  = '0;
         vx_new = -vx[idx];
      end else if (nx > X_LIM) begin
         x_new  = COORD_W'(X_MAX);
         vx_new = -vx[idx];
      end
      if (ny < 0) begin
         y_new  = '0;
         vy_new = -vy[idx];
      end else if (ny > Y_LIM) begin
         y_new  = COORD_W'(Y_MAX);
         vy_new = -vy[idx];
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state       <= IDLE;
         idx         <= '0;
         busy        <= 1'b0;
         overrun     <= 1'b0;
         frame_count <= '0;
         for (int i = 0; i < NUM_BALLS; i++) begin
            x_sh[i]                        <= rst_x(i);
            y_sh[i]                        <= RST_Y;
            vx[i]                          <= rst_vx(i);
            vy[i]                          <= rst_vy(i);
            ball_x[i*COORD_W +: COORD_W]   <= rst_x(i);
            ball_y[i*COORD_W +: COORD_W]   <= RST_Y;
         end
      end else begin
         case (state)
            IDLE: begin
               if (frame_tick && !paused) begin
                  state <= UPDATE;
                  idx   <= '0;
                  busy  <= 1'b1;
               end
            end
            UPDATE: begin
               x_sh[idx] <= x_new;
               y_sh[idx] <= y_new;
               vx[idx]   <= vx_new;
               vy[idx]   <= vy_new;
               if (idx == LAST) state <= COMMIT;
               else             idx   <= idx + IDX_W'(1);
            end
            COMMIT: begin
               // Publish only in blanking so the pixel datapath never sees a torn frame.
               if (!display) begin
                  for (int i = 0; i < NUM_BALLS; i++) begin
                     ball_x[i*COORD_W +: COORD_W] <= x_sh[i];
                     ball_y[i*COORD_W +: COORD_W] <= y_sh[i];
                  end
                  frame_count <= frame_count + 8'd1;
                  busy        <= 1'b0;
                  state       <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
         if (frame_tick && busy) overrun <= 1'b1;
      end
   end

endmodule

// File: tb/tb_metaball_motion_sched.sv
// tb/tb_metaball_motion_sched.sv - directed/randomized bench for metaball_motion_sched with a frame-level model
module tb_metaball_motion_sched;

   localparam int NB = 3;
   localparam int CW = 10;
   localparam int XM = 639;
   localparam int YM = 479;

   logic             clk = 1'b0;
   logic             reset = 1'b1;
   logic             frame_tick = 1'b0;
   logic             display = 1'b0;
`ifdef METABALL_PAUSE_EN
   logic             pause = 1'b0;
`endif
   logic [NB*CW-1:0] ball_x, ball_y;
   logic             busy, overrun;
   logic [7:0]       frame_count;

   int vectors = 0;
   int miscompares = 0;

   int mx [NB];
   int my [NB];
   int mvx [NB];
   int mvy [NB];
   int mfc;

   metaball_motion_sched dut (
      .clk         (clk),
      .reset       (reset),
      .frame_tick  (frame_tick),
      .display     (display),
`ifdef METABALL_PAUSE_EN
      .pause       (pause),
`endif
      .ball_x      (ball_x),
      .ball_y      (ball_y),
      .busy        (busy),
      .overrun     (overrun),
      .frame_count (frame_count)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input int obs, input int exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < NB; i++) begin
         mx[i]  = (i + 1) * XM / (NB + 1);
         my[i]  = YM / 2;
         mvx[i] = i + 1;
         mvy[i] = (i % 2 == 0) ? 2 : -2;
      end
      mfc = 0;
   endtask

   task automatic model_frame();
      for (int i = 0; i < NB; i++) begin
         int n;
         n = mx[i] + mvx[i];
         if (n < 0)       begin mx[i] = 0;  mvx[i] = -mvx[i]; end
         else if (n > XM) begin mx[i] = XM; mvx[i] = -mvx[i]; end
         else             mx[i] = n;
         n = my[i] + mvy[i];
         if (n < 0)       begin my[i] = 0;  mvy[i] = -mvy[i]; end
         else if (n > YM) begin my[i] = YM; mvy[i] = -mvy[i]; end
         else             my[i] = n;
      end
      mfc = (mfc + 1) % 256;
   endtask

   function automatic int bx(input int i);
      return int'(ball_x[i*CW +: CW]);
   endfunction

   function automatic int by(input int i);
      return int'(ball_y[i*CW +: CW]);
   endfunction

   task automatic check_outputs(input string tag);
      for (int i = 0; i < NB; i++) begin
         chk($sformatf("%s_x%0d", tag, i), bx(i), mx[i]);
         chk($sformatf("%s_y%0d", tag, i), by(i), my[i]);
      end
      chk({tag, "_fc"}, int'(frame_count), mfc);
   endtask

   task automatic edge1();
      @(posedge clk);
      #1;
   endtask

   // One full frame: tick, NB update cycles, then 'hold' commit cycles with display high.
   task automatic do_frame(input int hold, input bit full_check);
      display    = 1'b0;
      frame_tick = 1'b1;
      edge1();
      frame_tick = 1'b0;
      display    = (hold > 0);
      if (full_check) chk("busy_rise", int'(busy), 1);
      for (int k = 1; k <= NB; k++) begin
         edge1();
         if (full_check) begin
            chk("busy_upd", int'(busy), 1);
            check_outputs("upd_stable");
         end
      end
      for (int k = 0; k < hold; k++) begin
         edge1();
         if (full_check || k == hold - 1) begin
            chk("busy_hold", int'(busy), 1);
            check_outputs("disp_frozen");
         end
      end
      display = 1'b0;
      edge1();
      model_frame();
      chk("busy_fall", int'(busy), 0);
      check_outputs("commit");
      repeat ($urandom_range(0, 2)) edge1();
   endtask

   initial begin
      model_reset();
      #12;
      chk("rst_busy", int'(busy), 0);
      check_outputs("rst");
      reset = 1'b0;
      edge1();
      chk("rst_b0x", bx(0), 159);
      chk("rst_b1x", bx(1), 319);
      chk("rst_b2x", bx(2), 479);
      chk("rst_y1", by(1), 239);
      chk("rst_ovr", int'(overrun), 0);

      do_frame(0, 1'b1);
      chk("f1_b0x", bx(0), 160);
      chk("f1_b0y", by(0), 241);
      chk("f1_b1x", bx(1), 321);
      chk("f1_b1y", by(1), 237);
      chk("f1_b2x", bx(2), 482);
      chk("f1_b2y", by(2), 241);
      chk("f1_fc", int'(frame_count), 1);

      do_frame(20, 1'b1);

      while (mfc < 53) do_frame($urandom_range(0, 3), 1'b0);
      do_frame(0, 1'b0);
      chk("f54_b2x", bx(2), 639);
      do_frame(0, 1'b0);
      chk("f55_b2x", bx(2), 636);

      while (mfc < 119) do_frame($urandom_range(0, 3), 1'b0);
      do_frame(0, 1'b0);
      chk("f120_b1y", by(1), 0);
      do_frame(1, 1'b0);
      chk("f121_b1y", by(1), 2);
      chk("ovr_clean", int'(overrun), 0);

`ifdef METABALL_PAUSE_EN
      pause      = 1'b1;
      frame_tick = 1'b1;
      edge1();
      frame_tick = 1'b0;
      chk("pause_busy", int'(busy), 0);
      repeat (NB + 2) edge1();
      chk("pause_busy2", int'(busy), 0);
      check_outputs("pause");
      chk("pause_ovr", int'(overrun), 0);
      pause = 1'b0;
      do_frame(0, 1'b1);
`endif

      // Extra tick during UPDATE: ignored, only sets overrun.
      frame_tick = 1'b1;
      edge1();
      frame_tick = 1'b0;
      edge1();
      frame_tick = 1'b1;
      edge1();
      frame_tick = 1'b0;
      chk("ovr_set", int'(overrun), 1);
      edge1();
      edge1();
      model_frame();
      check_outputs("ovr_commit");
      chk("ovr_busy", int'(busy), 0);
      repeat (NB + 3) edge1();
      chk("ovr_fc_once", int'(frame_count), mfc);
      chk("ovr_sticky", int'(overrun), 1);

      // Asynchronous reset in the middle of UPDATE.
      frame_tick = 1'b1;
      edge1();
      frame_tick = 1'b0;
      edge1();
      #2;
      reset = 1'b1;
      #1;
      model_reset();
      check_outputs("async_rst");
      chk("async_busy", int'(busy), 0);
      chk("async_ovr", int'(overrun), 0);
      edge1();
      reset = 1'b0;
      edge1();
      do_frame($urandom_range(0, 2), 1'b1);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
